// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard-based hazard controller for the pipelined MIPS datapath.
// Tracks in-flight register writes from EX up to (not including) writeback and
// produces PC/IF-ID/ID-EX stall, freeze and flush controls plus a stall counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned FWD_EN = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic              dec_rs_used,
  input  logic              dec_rt_used,
  input  logic [REG_AW-1:0] dec_wsel,
  input  logic              dec_wen,
  input  logic              dec_load,
  input  logic              jumpBranch,
  input  logic              mem_busy,
  output logic              stallPC,
  output logic              ifidFreeze,
  output logic              ifidFlush,
  output logic              idexFlush,
  output logic              pipeFreeze,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Entry 0 is the instruction in EX; entry DEPTH-1 is the oldest still tracked.
  logic [DEPTH-1:0]             sb_valid_q, sb_valid_d;
  logic [DEPTH-1:0]             sb_load_q, sb_load_d;
  logic [DEPTH-1:0][REG_AW-1:0] sb_wsel_q, sb_wsel_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0] match;
  logic             hazard;
  logic             hazard_cycle;
  logic             issue;

  // Compare each pending destination against the decode sources actually read.
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match[i] = sb_valid_q[i] && (sb_wsel_q[i] != '0) &&
                 ((dec_rs_used && (sb_wsel_q[i] == dec_rs)) ||
                  (dec_rt_used && (sb_wsel_q[i] == dec_rt)));
    end
    // With forwarding only a load still in EX cannot supply its result in time.
    if (FWD_EN != 0) begin
      hazard = dec_valid && match[0] && sb_load_q[0];
    end else begin
      hazard = dec_valid && (|match);
    end
  end

  assign hazard_cycle = hazard && !mem_busy && !jumpBranch;
  assign issue        = dec_valid && !mem_busy && !jumpBranch && !hazard;

  // Prioritised pipeline control: memory hold, then redirect flush, then data stall.
  always_comb begin
    stallPC    = 1'b0;
    ifidFreeze = 1'b0;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    pipeFreeze = 1'b0;
    if (mem_busy) begin
      pipeFreeze = 1'b1;
      stallPC    = 1'b1;
      ifidFreeze = 1'b1;
    end else if (jumpBranch) begin
      // The decode instruction is discarded, so any hazard it has is moot.
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end else if (hazard) begin
      stallPC    = 1'b1;
      ifidFreeze = 1'b1;
      idexFlush  = 1'b1;
    end
  end

  // Scoreboard ageing and saturating stall counter next-state.
  always_comb begin
    sb_valid_d  = sb_valid_q;
    sb_load_d   = sb_load_q;
    sb_wsel_d   = sb_wsel_q;
    stall_cnt_d = stall_cnt_q;
    if (!mem_busy) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        sb_valid_d[i] = sb_valid_q[i-1];
        sb_load_d[i]  = sb_load_q[i-1];
        sb_wsel_d[i]  = sb_wsel_q[i-1];
      end
      sb_valid_d[0] = issue && dec_wen;
      sb_load_d[0]  = dec_load;
      sb_wsel_d[0]  = dec_wsel;
    end
    if (hazard_cycle && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb_valid_q  <= '0;
      sb_load_q   <= '0;
      sb_wsel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_valid_q  <= sb_valid_d;
      sb_load_q   <= sb_load_d;
      sb_wsel_q   <= sb_wsel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Three instances share stimulus:
// u0 = no forwarding, u1 = forwarding, u2 = no forwarding with a 2-bit counter.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dec_valid, rs_used, rt_used, dec_wen, dec_load, jump_branch, mem_busy;
  logic [4:0] dec_rs, dec_rt, dec_wsel;

  logic [2:0]  stall_pc, ifid_freeze, ifid_flush, idex_flush, pipe_freeze;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .FWD_EN(0), .CNT_W(16)) u0 (
    .CLK(clk), .nRST(rst_n), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(rs_used), .dec_rt_used(rt_used), .dec_wsel(dec_wsel), .dec_wen(dec_wen),
    .dec_load(dec_load), .jumpBranch(jump_branch), .mem_busy(mem_busy),
    .stallPC(stall_pc[0]), .ifidFreeze(ifid_freeze[0]), .ifidFlush(ifid_flush[0]),
    .idexFlush(idex_flush[0]), .pipeFreeze(pipe_freeze[0]), .stall_cnt(cnt0)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) u1 (
    .CLK(clk), .nRST(rst_n), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(rs_used), .dec_rt_used(rt_used), .dec_wsel(dec_wsel), .dec_wen(dec_wen),
    .dec_load(dec_load), .jumpBranch(jump_branch), .mem_busy(mem_busy),
    .stallPC(stall_pc[1]), .ifidFreeze(ifid_freeze[1]), .ifidFlush(ifid_flush[1]),
    .idexFlush(idex_flush[1]), .pipeFreeze(pipe_freeze[1]), .stall_cnt(cnt1)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .FWD_EN(0), .CNT_W(2)) u2 (
    .CLK(clk), .nRST(rst_n), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(rs_used), .dec_rt_used(rt_used), .dec_wsel(dec_wsel), .dec_wen(dec_wen),
    .dec_load(dec_load), .jumpBranch(jump_branch), .mem_busy(mem_busy),
    .stallPC(stall_pc[2]), .ifidFreeze(ifid_freeze[2]), .ifidFlush(ifid_flush[2]),
    .idexFlush(idex_flush[2]), .pipeFreeze(pipe_freeze[2]), .stall_cnt(cnt2)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; rs_used = 0; rt_used = 0; dec_wen = 0; dec_load = 0;
    dec_rs = 0; dec_rt = 0; dec_wsel = 0; jump_branch = 0; mem_busy = 0;
  endtask

  task automatic instr(input logic [4:0] wsel, input logic wen, input logic ld,
                       input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu);
    dec_valid = 1; dec_wsel = wsel; dec_wen = wen; dec_load = ld;
    dec_rs = rs; rs_used = rsu; dec_rt = rt; rt_used = rtu;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    rst_n = 1;
    next_cycle();
  endtask

  // Reset asserted while u0 is stalling clears the scoreboard and counter at once.
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({stall_pc, ifid_freeze, ifid_flush, idex_flush, pipe_freeze} !== 15'd0) begin
      errors++; $display("FAIL reset_idle outputs got %h want 0",
                         {stall_pc, ifid_freeze, ifid_flush, idex_flush, pipe_freeze});
    end
    checks++;
    if (cnt0 !== 16'd0 || cnt2 !== 2'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt0, cnt2);
    end
    next_cycle();
    instr(5'd3, 1, 0, 5'd1, 1, 5'd2, 1);
    next_cycle();
    instr(5'd5, 1, 0, 5'd3, 1, 5'd4, 1);
    @(negedge clk);
    checks++;
    if (stall_pc[0] !== 1'b1) begin
      errors++; $display("FAIL reset_pre_stall stallPC got %b want 1", stall_pc[0]);
    end
    next_cycle();
    #2 rst_n = 0;
    #1;
    checks++;
    if (stall_pc[0] !== 1'b0 || cnt0 !== 16'd0) begin
      errors++; $display("FAIL reset_mid_stall stallPC/cnt got %b/%0d want 0/0",
                         stall_pc[0], cnt0);
    end
    dec_valid = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if ({stall_pc, ifid_freeze, ifid_flush, idex_flush, pipe_freeze} !== 15'd0) begin
      errors++; $display("FAIL reset_after outputs got %h want 0",
                         {stall_pc, ifid_freeze, ifid_flush, idex_flush, pipe_freeze});
    end
    next_cycle();
    instr(5'd5, 1, 0, 5'd3, 1, 5'd4, 1);
    @(negedge clk);
    checks++;
    if (stall_pc[0] !== 1'b0) begin
      errors++; $display("FAIL reset_reissue stallPC got %b want 0", stall_pc[0]);
    end
    next_cycle();
    idle();
  endtask

  // add $3 then sub reading $3: three stalls without forwarding, none with it.
  task automatic test_dep_alu();
    int n0 = 0, n1 = 0, n2 = 0, bad = 0;
    do_reset();
    instr(5'd3, 1, 0, 5'd1, 1, 5'd2, 1);
    next_cycle();
    instr(5'd5, 1, 0, 5'd3, 1, 5'd4, 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (stall_pc == 3'b000) break;
      n0 += int'(stall_pc[0]); n1 += int'(stall_pc[1]); n2 += int'(stall_pc[2]);
      if (stall_pc[0] && !(ifid_freeze[0] && idex_flush[0] && !ifid_flush[0] &&
                           !pipe_freeze[0])) bad++;
      next_cycle();
    end
    checks++;
    if (n0 != 3) begin errors++; $display("FAIL alu_stalls_nofwd got %0d want 3", n0); end
    checks++;
    if (n1 != 0) begin errors++; $display("FAIL alu_stalls_fwd got %0d want 0", n1); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL alu_stall_ctrl bad cycles %0d want 0", bad); end
    checks++;
    if (cnt0 !== 16'd3 || cnt1 !== 16'd0 || cnt2 !== 2'd3) begin
      errors++; $display("FAIL alu_cnt got %0d/%0d/%0d want 3/0/3", cnt0, cnt1, cnt2);
    end
    next_cycle();
    idle();
  endtask

  // lw $5 then add reading $5: one stall with forwarding.
  task automatic test_load_use();
    int n0 = 0, n1 = 0;
    do_reset();
    instr(5'd5, 1, 1, 5'd1, 1, 5'd0, 0);
    next_cycle();
    instr(5'd6, 1, 0, 5'd5, 1, 5'd5, 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (stall_pc == 3'b000) break;
      n0 += int'(stall_pc[0]); n1 += int'(stall_pc[1]);
      next_cycle();
    end
    checks++;
    if (n1 != 1) begin errors++; $display("FAIL load_use_fwd got %0d want 1", n1); end
    checks++;
    if (n0 != 3) begin errors++; $display("FAIL load_use_nofwd got %0d want 3", n0); end
    checks++;
    if (cnt1 !== 16'd1) begin errors++; $display("FAIL load_use_cnt got %0d want 1", cnt1); end
    next_cycle();
    idle();
  endtask

  // mem_busy for two cycles mid-stall stretches it to five without counting.
  task automatic test_mem_busy();
    int n0 = 0, pf = 0, bad = 0;
    do_reset();
    instr(5'd3, 1, 0, 5'd1, 1, 5'd2, 1);
    next_cycle();
    instr(5'd5, 1, 0, 5'd3, 1, 5'd4, 1);
    for (int k = 0; k < 12; k++) begin
      mem_busy = (k == 1 || k == 2);
      @(negedge clk);
      if (!stall_pc[0]) break;
      n0++;
      if (pipe_freeze[0]) begin
        pf++;
        if (!ifid_freeze[0] || idex_flush[0] || ifid_flush[0]) bad++;
      end
      next_cycle();
    end
    mem_busy = 0;
    checks++;
    if (n0 != 5) begin errors++; $display("FAIL busy_stall_len got %0d want 5", n0); end
    checks++;
    if (pf != 2) begin errors++; $display("FAIL busy_freeze_len got %0d want 2", pf); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_ctrl bad cycles %0d want 0", bad); end
    checks++;
    if (cnt0 !== 16'd3) begin errors++; $display("FAIL busy_cnt got %0d want 3", cnt0); end
    next_cycle();
    idle();
  endtask

  // Redirect while decode depends on a load in EX: flush only, instruction squashed.
  task automatic test_jump_branch();
    do_reset();
    mem_busy = 1; jump_branch = 1;
    @(negedge clk);
    checks++;
    if ({pipe_freeze[0], stall_pc[0], ifid_freeze[0], ifid_flush[0], idex_flush[0]}
        !== 5'b11100) begin
      errors++; $display("FAIL busy_over_jb got %b want 11100",
        {pipe_freeze[0], stall_pc[0], ifid_freeze[0], ifid_flush[0], idex_flush[0]});
    end
    next_cycle();
    idle();
    instr(5'd3, 1, 1, 5'd1, 1, 5'd0, 0);
    next_cycle();
    instr(5'd7, 1, 1, 5'd3, 1, 5'd0, 0);
    jump_branch = 1;
    @(negedge clk);
    checks++;
    if ({ifid_flush[1:0], idex_flush[1:0], stall_pc[1:0], ifid_freeze[1:0], pipe_freeze[1:0]}
        !== 10'b1111000000) begin
      errors++; $display("FAIL jb_flush got %b want 1111000000",
        {ifid_flush[1:0], idex_flush[1:0], stall_pc[1:0], ifid_freeze[1:0], pipe_freeze[1:0]});
    end
    next_cycle();
    jump_branch = 0;
    instr(5'd8, 1, 0, 5'd7, 1, 5'd0, 0);
    @(negedge clk);
    checks++;
    if (stall_pc[1:0] !== 2'b00) begin
      errors++; $display("FAIL jb_squashed stallPC got %b want 00", stall_pc[1:0]);
    end
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      errors++; $display("FAIL jb_cnt got %0d/%0d want 0/0", cnt0, cnt1);
    end
    next_cycle();
    idle();
  endtask

  // Register 0, unused sources and invalid decode never stall.
  task automatic test_zero_unused();
    do_reset();
    instr(5'd0, 1, 0, 5'd1, 1, 5'd2, 1);
    next_cycle();
    instr(5'd0, 0, 0, 5'd0, 1, 5'd0, 1);
    @(negedge clk);
    checks++;
    if (stall_pc[0] !== 1'b0) begin errors++; $display("FAIL reg0 stallPC got %b want 0", stall_pc[0]); end
    next_cycle();
    instr(5'd4, 1, 0, 5'd1, 1, 5'd2, 1);
    next_cycle();
    instr(5'd0, 0, 0, 5'd1, 1, 5'd4, 0);
    @(negedge clk);
    checks++;
    if (stall_pc[0] !== 1'b0) begin errors++; $display("FAIL rt_unused stallPC got %b want 0", stall_pc[0]); end
    next_cycle();
    instr(5'd0, 0, 0, 5'd4, 0, 5'd2, 1);
    @(negedge clk);
    checks++;
    if (stall_pc[0] !== 1'b0) begin errors++; $display("FAIL rs_unused stallPC got %b want 0", stall_pc[0]); end
    next_cycle();
    instr(5'd0, 0, 0, 5'd4, 1, 5'd0, 0);
    dec_valid = 0;
    @(negedge clk);
    checks++;
    if (stall_pc[0] !== 1'b0) begin errors++; $display("FAIL dec_invalid stallPC got %b want 0", stall_pc[0]); end
    dec_valid = 1;
    #1;
    checks++;
    if (stall_pc[0] !== 1'b1) begin errors++; $display("FAIL oldest_entry stallPC got %b want 1", stall_pc[0]); end
    next_cycle();
    idle();
  endtask

  // Five counted stalls: 16-bit counter reads 5, 2-bit counter pins at 3.
  task automatic test_saturate();
    do_reset();
    instr(5'd3, 1, 0, 5'd1, 1, 5'd2, 1);
    next_cycle();
    instr(5'd5, 1, 0, 5'd3, 1, 5'd0, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!stall_pc[0]) break;
      next_cycle();
    end
    next_cycle();
    instr(5'd4, 1, 0, 5'd1, 1, 5'd2, 1);
    next_cycle();
    instr(5'd0, 0, 0, 5'd1, 1, 5'd2, 1);
    next_cycle();
    instr(5'd9, 1, 0, 5'd4, 1, 5'd0, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!stall_pc[0]) break;
      next_cycle();
    end
    checks++;
    if (cnt0 !== 16'd5) begin errors++; $display("FAIL sat_cnt16 got %0d want 5", cnt0); end
    checks++;
    if (cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d want 3", cnt2); end
    next_cycle();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_dep_alu();
    test_load_use();
    test_mem_busy();
    test_jump_branch();
    test_zero_unused();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
